alu_arbiter: RTL and testbench

Shares the single ALU between two requesters (lane 0: core execute stage, lane 1: auxiliary/debug unit) using valid/ready handshakes and round-robin arbitration. It latches the winning request, drives the ALU `write` strobe for one cycle, waits the ALU result latency, captures `result`/`cnzv`, and returns them to the owning lane. One operation is in flight at a time. The block sits between the requesters and the ALU and is the only driver of the ALU input ports.

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// One operation in flight; the result is captured and returned to the owning lane.
module alu_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [9:0]                req_operation,
  input  logic [2*DATA_WIDTH-1:0]   req_a,
  input  logic [2*DATA_WIDTH-1:0]   req_b,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_result,
  output logic [3:0]                rsp_cnzv,
  output logic                      alu_write,
  output logic [4:0]                alu_operation,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  output logic                      alu_use_pc,
  output logic                      alu_use_immediate,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [3:0]                alu_cnzv
);
  localparam int NUM_LANES = 2;
  localparam int CNT_W     = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] EXECUTE = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;

  logic [NUM_LANES-1:0][4:0]            lane_op;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_a, lane_b;

  assign lane_op = req_operation;
  assign lane_a  = req_a;
  assign lane_b  = req_b;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [3:0]            cnzv_q, cnzv_d;
  logic                  winner;

  // On contention the lane that was not served last wins.
  assign winner = (&req_valid) ? ~last_grant_q : req_valid[1];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    cnzv_d       = cnzv_q;
    req_ready    = '0;
    rsp_valid    = '0;
    case (state_q)
      IDLE: begin
        // Gated by reset so a held request never sees ready during reset.
        if ((|req_valid) && reset_n) begin
          req_ready[winner] = 1'b1;
          owner_d           = winner;
          last_grant_d      = winner;
          op_d              = lane_op[winner];
          a_d               = lane_a[winner];
          b_d               = lane_b[winner];
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(ALU_LATENCY);
        state_d = EXECUTE;
      end
      EXECUTE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = alu_result;
          cnzv_d  = alu_cnzv;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cnzv_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      cnzv_q       <= cnzv_d;
    end
  end

  assign alu_write         = (state_q == ISSUE);
  assign alu_operation     = op_q;
  assign alu_a             = a_q;
  assign alu_b             = b_q;
  assign alu_use_pc        = 1'b0;
  assign alu_use_immediate = 1'b0;
  assign rsp_result        = res_q;
  assign rsp_cnzv          = cnzv_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at latency 1, one at latency 3,
// each fed by a small behavioural ALU.
module tb_alu_arbiter;
  logic        clock;
  logic        rst1_n, rst2_n;
  logic [1:0]  req_valid, rsp_ready;
  logic [9:0]  req_operation;
  logic [63:0] req_a, req_b;
  logic        sel;

  logic [1:0]  rr1, rv1, rr2, rv2;
  logic [31:0] res1, res2, a1, a2, b1, b2, ar1, ar2;
  logic [3:0]  f1, f2, af1, af2;
  logic        w1, w2, pc1, pc2, im1, im2;
  logic [4:0]  op1, op2;

  logic [1:0]  o_req_ready, o_rsp_valid;
  logic [31:0] o_res, o_a, o_b;
  logic [3:0]  o_cnzv;
  logic        o_write, o_pc, o_imm;
  logic [4:0]  o_op;

  int n_chk, n_pass, wr_cnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  alu_arbiter #(.DATA_WIDTH(32), .ALU_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(rst1_n), .req_valid(req_valid), .req_ready(rr1),
    .req_operation(req_operation), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_result(res1), .rsp_cnzv(f1),
    .alu_write(w1), .alu_operation(op1), .alu_a(a1), .alu_b(b1),
    .alu_use_pc(pc1), .alu_use_immediate(im1), .alu_result(ar1), .alu_cnzv(af1));

  alu_arbiter #(.DATA_WIDTH(32), .ALU_LATENCY(3)) dut2 (
    .clock(clock), .reset_n(rst2_n), .req_valid(req_valid), .req_ready(rr2),
    .req_operation(req_operation), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_result(res2), .rsp_cnzv(f2),
    .alu_write(w2), .alu_operation(op2), .alu_a(a2), .alu_b(b2),
    .alu_use_pc(pc2), .alu_use_immediate(im2), .alu_result(ar2), .alu_cnzv(af2));

  // Reference ALU: returns {C,N,Z,V,result}.
  function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a, b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; r = '0; s = '0;
    case (op)
      5'd0:  begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                   v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd16: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                   v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd7:  r = a & b;
      5'd21: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    return {c, r[31], (r == 32'd0), v, r};
  endfunction

  logic [35:0] lat1, lat2;
  always @(posedge clock) begin
    if (w1) lat1 <= alu_fn(op1, a1, b1);
    if (w2) lat2 <= alu_fn(op2, a2, b2);
    if (o_write) wr_cnt <= wr_cnt + 1;
  end
  assign {af1, ar1} = lat1;
  assign {af2, ar2} = lat2;

  always_comb begin
    o_req_ready = sel ? rr2  : rr1;
    o_rsp_valid = sel ? rv2  : rv1;
    o_res       = sel ? res2 : res1;
    o_cnzv      = sel ? f2   : f1;
    o_write     = sel ? w2   : w1;
    o_op        = sel ? op2  : op1;
    o_a         = sel ? a2   : a1;
    o_b         = sel ? b2   : b1;
    o_pc        = sel ? pc2  : pc1;
    o_imm       = sel ? im2  : im1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input int lane, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_operation[5*lane +: 5] = op;
    req_a[32*lane +: 32]       = a;
    req_b[32*lane +: 32]       = b;
  endtask

  // Called between edges; returns edges waited until rsp_valid[lane] rises.
  task automatic wait_rsp(input int lane, output int n);
    n = 0;
    while (o_rsp_valid[lane] !== 1'b1 && n < 30) begin
      @(posedge clock); #1; n++;
    end
  endtask

  task automatic do_op(input int lane, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [3:0] f, input int lat);
    int n, w0;
    logic [1:0] oh;
    oh = 2'b01 << lane;
    @(negedge clock);
    drive(lane, op, a, b);
    req_valid[lane] = 1'b1;
    #1 chk("accept_ready", o_req_ready, oh);
    w0 = wr_cnt;
    @(posedge clock);
    @(negedge clock);
    req_valid[lane] = 1'b0;
    chk("alu_write", o_write, 1);
    chk("alu_operation", o_op, op);
    chk("alu_a", o_a, a);
    chk("alu_b", o_b, b);
    wait_rsp(lane, n);
    chk("rsp_latency", n, lat);
    chk("rsp_valid", o_rsp_valid, oh);
    chk("rsp_result", o_res, r);
    chk("rsp_cnzv", o_cnzv, f);
    chk("write_pulses", wr_cnt - w0, 1);
    @(negedge clock);
    rsp_ready = oh;
    @(posedge clock);
    #1 chk("rsp_done", o_rsp_valid, 2'b00);
    @(negedge clock);
    rsp_ready = 2'b00;
  endtask

  typedef struct {
    int          lane;
    logic [4:0]  op;
    logic [31:0] a, b, r;
    logic [3:0]  f;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n, acc, cyc;
    int gl[4];
    int gc[4];
    logic seen;

    vt[0] = '{0, 5'd0,  32'hFFFFFFCE, 32'd43,       32'hFFFFFFF9, 4'b0100};
    vt[1] = '{1, 5'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b0101};
    vt[2] = '{0, 5'd21, 32'hFFFFFFF0, 32'd2,        32'hFFFFFFFC, 4'b0100};
    vt[3] = '{1, 5'd0,  32'hFFFFFFFF, 32'd1,        32'h00000000, 4'b1010};
    vt[4] = '{0, 5'd7,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0010};
    vt[5] = '{1, 5'd16, 32'd100,      32'd43,       32'd57,       4'b1000};

    n_chk = 0; n_pass = 0; wr_cnt = 0;
    sel = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_operation = '0; req_a = '0; req_b = '0;

    // Reset state, with requests held during reset.
    repeat (2) @(negedge clock);
    req_valid = 2'b11;
    #1 chk("reset_req_ready", o_req_ready, 2'b00);
    req_valid = 2'b00;
    @(negedge clock);
    rst1_n = 1'b1;
    #1;
    chk("reset_rsp_valid", o_rsp_valid, 2'b00);
    chk("reset_alu_write", o_write, 0);
    chk("reset_alu_a", o_a, 0);
    chk("reset_alu_op", o_op, 0);
    chk("reset_rsp_result", o_res, 0);
    chk("reset_use_pc_imm", {o_pc, o_imm}, 2'b00);

    // Simultaneous first request: lane 0 first, lane 1 waits.
    @(negedge clock);
    drive(0, 5'd0, 32'd15, 32'd27);
    drive(1, 5'd7, 32'd15, 32'd27);
    req_valid = 2'b11;
    #1 chk("sim_first_grant", o_req_ready, 2'b01);
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b10;
    #1 chk("sim_lane1_wait", o_req_ready, 2'b00);
    wait_rsp(0, n);
    chk("sim_lat0", n, 2);
    chk("sim_result0", o_res, 42);
    @(negedge clock);
    rsp_ready = 2'b01;
    #1 chk("sim_no_accept_in_respond", o_req_ready, 2'b00);
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 2'b00;
    #1 chk("sim_second_grant", o_req_ready, 2'b10);
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    wait_rsp(1, n);
    chk("sim_result1", o_res, 11);
    chk("sim_rsp_lane1", o_rsp_valid, 2'b10);
    @(negedge clock);
    rsp_ready = 2'b10;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 2'b00;

    // Continuous contention.
    drive(0, 5'd0, 32'd1, 32'd2);
    drive(1, 5'd0, 32'd3, 32'd4);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    acc = 0; cyc = 0;
    while (acc < 4 && cyc < 40) begin
      #1;
      if (o_req_ready != 2'b00) begin
        gl[acc] = int'(o_req_ready[1]);
        gc[acc] = cyc;
        acc++;
      end
      @(negedge clock);
      cyc++;
    end
    req_valid = 2'b00;
    repeat (5) @(negedge clock);
    rsp_ready = 2'b00;
    chk("cont_accepts", acc, 4);
    for (int i = 0; i < 4; i++) chk("cont_grant_order", gl[i], i % 2);
    for (int i = 1; i < 4; i++) chk("cont_spacing", gc[i] - gc[i-1], 4);

    // Backpressure on lane 1 with lane 0 pending.
    @(negedge clock);
    drive(1, 5'd0, 32'h7FFFFFFF, 32'd1);
    req_valid = 2'b10;
    #1 chk("bp_grant", o_req_ready, 2'b10);
    @(posedge clock);
    @(negedge clock);
    drive(0, 5'd0, 32'd2, 32'd3);
    req_valid = 2'b01;
    wait_rsp(1, n);
    chk("bp_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      rsp_ready = 2'b01;
      #1;
      chk("bp_rsp_valid", o_rsp_valid, 2'b10);
      chk("bp_result", o_res, 32'h80000000);
      chk("bp_cnzv", o_cnzv, 4'b0101);
      chk("bp_req_ready", o_req_ready, 2'b00);
    end
    @(negedge clock);
    rsp_ready = 2'b10;
    @(posedge clock);
    #1;
    chk("bp_released", o_rsp_valid, 2'b00);
    chk("bp_lane0_grant", o_req_ready, 2'b01);
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    wait_rsp(0, n);
    chk("bp_lane0_result", o_res, 5);
    @(negedge clock);
    rsp_ready = 2'b01;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 2'b00;

    // Vector table at latency 1.
    for (int i = 0; i < 6; i++)
      do_op(vt[i].lane, vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].f, 2);

    // Latency-3 instance: normal op, then reset mid-EXECUTE.
    @(negedge clock);
    rst1_n = 1'b0;
    sel = 1'b1;
    rst2_n = 1'b1;
    do_op(0, 5'd7, 32'd15, 32'd27, 32'd11, 4'b0000, 4);

    @(negedge clock);
    drive(0, 5'd16, 32'd100, 32'd43);
    req_valid = 2'b01;
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    chk("l3_alu_write", o_write, 1);
    @(posedge clock);
    @(negedge clock);
    rst2_n = 1'b0;
    #1;
    chk("mid_rst_write", o_write, 0);
    chk("mid_rst_rsp_valid", o_rsp_valid, 2'b00);
    chk("mid_rst_req_ready", o_req_ready, 2'b00);
    chk("mid_rst_alu_a", o_a, 0);
    chk("mid_rst_alu_op", o_op, 0);
    chk("mid_rst_result", o_res, 0);
    repeat (2) @(negedge clock);
    rst2_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1 if (o_rsp_valid != 2'b00) seen = 1'b1;
    end
    chk("mid_rst_no_rsp", seen, 0);
    do_op(0, 5'd16, 32'd100, 32'd43, 32'd57, 4'b1000, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
